// File: rtl/nibble_add_seq.sv
//-----------------------------------------------------------------------------
// Module   : nibble_add_seq
// Purpose  : Sequential multi-nibble adder.  An operand pair (X, Y) of WORDS
//            nibbles plus a carry-in is summed one nibble per clock through an
//            external combinational 4-bit adder, least-significant nibble
//            first.  The result is registered on SUM/COUT and flagged by a
//            one-cycle DONE pulse.
// Ports    : CLK, RST_N          - clock, asynchronous active-low reset
//            START, X, Y, CIN    - request and operands (sampled in IDLE)
//            ADD_A/ADD_B/ADD_C0  - operands to the external 4-bit adder
//            ADD_F/ADD_C4        - sum nibble and carry from that adder
//            BUSY, DONE          - status (BUSY in RUN/FIN, DONE in FIN)
//            SUM, COUT           - registered result
// Revision : 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

module nibble_add_seq #(
  parameter int WORDS = 4
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               START,
  input  logic [4*WORDS-1:0] X,
  input  logic [4*WORDS-1:0] Y,
  input  logic               CIN,
  output logic [3:0]         ADD_A,
  output logic [3:0]         ADD_B,
  output logic               ADD_C0,
  input  logic [3:0]         ADD_F,
  input  logic               ADD_C4,
  output logic               BUSY,
  output logic               DONE,
  output logic [4*WORDS-1:0] SUM,
  output logic               COUT
);

  // Index width: at least one bit so WORDS=1 still has a legal vector.
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] C_LAST_IDX = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 carry_q, carry_d;
  logic [4*WORDS-1:0]   x_q, x_d;
  logic [4*WORDS-1:0]   y_q, y_d;
  logic [4*WORDS-1:0]   sum_q, sum_d;
  logic                 cout_q, cout_d;

  // Bit offset of the active nibble (index * 4).
  logic [IW+1:0]        w_base;
  assign w_base = {idx_q, 2'b00};

  // State register and datapath registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      x_q     <= x_d;
      y_q     <= y_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    x_d     = x_q;
    y_d     = y_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ADD_A   = 4'h0;
    ADD_B   = 4'h0;
    ADD_C0  = 1'b0;
    BUSY    = 1'b0;
    DONE    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          x_d     = X;
          y_d     = Y;
          carry_d = CIN;
          sum_d   = '0;
          cout_d  = 1'b0;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        BUSY   = 1'b1;
        ADD_A  = x_q[w_base +: 4];
        ADD_B  = y_q[w_base +: 4];
        ADD_C0 = carry_q;
        sum_d[w_base +: 4] = ADD_F;
        carry_d = ADD_C4;
        if (idx_q == C_LAST_IDX) begin
          cout_d  = ADD_C4;
          idx_d   = '0;
          state_d = S_FIN;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      S_FIN: begin
        BUSY    = 1'b1;
        DONE    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign SUM  = sum_q;
  assign COUT = cout_q;

endmodule

`default_nettype wire
